alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. ADD/SUB/AND/OR/XOR/SHL/SRA complete in one clock.
// MUL is a sequential shift-add over N clocks.
//
// Ports:
//   clk       : clock; every state change happens on its rising edge.
//   rst       : asynchronous, active-high reset.
//   start     : request strobe; only looked at while idle.
//   op        : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SRA, 111 MUL.
//   a, b      : signed two's-complement operands, captured on the accepting edge.
//   busy      : high while a MUL is in progress.
//   done      : one-cycle pulse that marks a new result.
//   dout      : registered result.
//   overflow, zero, negative, carry : registered flags; they change only with dout.
module alu_mc #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dout,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         carry
);

  localparam int unsigned SW = $clog2(N);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic           neg_q, neg_d;
  logic           carry_q, carry_d;
  logic           done_q, done_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]  cnt_q, cnt_d;

  // Single-cycle datapath.
  logic [N:0]     add_w, sub_w, shl_w, sra_w;
  logic [N-1:0]   res;
  logic           res_v, res_c;

  // Multiplier step.
  logic           last;
  logic [2*N-1:0] step_w;
  logic           mul_ovf;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  // One spare bit catches the last bit shifted out; it is 0 when the shift amount is 0.
  assign shl_w = {1'b0, a} << b[SW-1:0];
  assign sra_w = $unsigned($signed({a, 1'b0}) >>> b[SW-1:0]);

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    res_c = 1'b0;
    case (op)
      3'b000: begin
        res   = add_w[N-1:0];
        res_c = add_w[N];
        res_v = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      3'b001: begin
        res   = sub_w[N-1:0];
        res_c = ~sub_w[N];  // not-borrow
        res_v = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: begin
        res   = shl_w[N-1:0];
        res_c = shl_w[N];
      end
      3'b110: begin
        res   = sra_w[N:1];
        res_c = sra_w[0];
      end
      default: ;
    endcase
  end

  // Multiplier bit N-1 carries weight -2^(N-1) in two's complement, so the
  // final step subtracts the multiplicand instead of adding it.
  assign last   = (cnt_q == SW'(N - 1));
  assign step_w = !mplier_q[0] ? acc_q :
                  last         ? acc_q - mcand_q : acc_q + mcand_q;
  // The product fits in N bits only if bits [2N-1:N-1] are all equal.
  assign mul_ovf = !((&step_w[2*N-1:N-1]) || !(|step_w[2*N-1:N-1]));

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == 3'b111) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = {{N{a[N-1]}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            dout_d  = res;
            ovf_d   = res_v;
            carry_d = res_c;
            zero_d  = (res == '0);
            neg_d   = res[N-1];
            done_d  = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = step_w;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (last) begin
          state_d = StIdle;
          dout_d  = step_w[N-1:0];
          ovf_d   = mul_ovf;
          carry_d = 1'b0;
          zero_d  = (step_w[N-1:0] == '0);
          neg_d   = step_w[N-1];
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy     = (state_q == StMul);
  assign done     = done_q;
  assign dout     = dout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc with N=16. Flags are compared as {overflow, zero, negative, carry}.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done, overflow, zero, negative, carry;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;

  int   lat, ndone;
  logic busy_ok;

  alu_mc #(.N(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one edge; returns #1 after that edge.
  task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start a MUL, then watch 24 edges. Optionally inject an ADD start at edge inj.
  task automatic mul_run(input logic [15:0] x, input logic [15:0] y, input int inj,
                         output int l, output int nd, output logic bok);
    do_op(3'b111, x, y);
    bok = busy & ~done;
    l   = -1;
    nd  = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i == inj) begin
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        nd++;
        if (l < 0) l = i;
      end
      if (l < 0 && !busy) bok = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    chk("reset_ctl", {busy, done, overflow, zero, negative, carry}, 6'b0);
    chk("reset_dout", dout, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(3'b000, 16'h7fff, 16'h0001);
    chk("add_ovf_done", done, 1'b1);
    chk("add_ovf_dout", dout, 16'h8000);
    chk("add_ovf_flags", {overflow, zero, negative, carry}, 4'b1010);
    @(posedge clk); #1;
    chk("add_done_pulse", done, 1'b0);
    chk("add_hold_dout", dout, 16'h8000);
    chk("add_hold_flags", {overflow, zero, negative, carry}, 4'b1010);

    do_op(3'b001, 16'h0005, 16'h0005);
    chk("sub_eq_dout", dout, 16'h0000);
    chk("sub_eq_flags", {overflow, zero, negative, carry}, 4'b0101);

    do_op(3'b001, 16'h0000, 16'h0001);
    chk("sub_borrow_dout", dout, 16'hffff);
    chk("sub_borrow_flags", {overflow, zero, negative, carry}, 4'b0010);

    do_op(3'b101, 16'h8001, 16'h0001);
    chk("shl_dout", dout, 16'h0002);
    chk("shl_flags", {overflow, zero, negative, carry}, 4'b0001);

    do_op(3'b110, 16'h8000, 16'h000f);
    chk("sra_dout", dout, 16'hffff);
    chk("sra_flags", {overflow, zero, negative, carry}, 4'b0010);

    do_op(3'b101, 16'h1234, 16'h0010);  // shift amount uses b[3:0] only -> 0
    chk("shl0_dout", dout, 16'h1234);
    chk("shl0_flags", {overflow, zero, negative, carry}, 4'b0000);

    do_op(3'b010, 16'hff0f, 16'h0ff0);
    chk("and_dout", dout, 16'h0f00);
    do_op(3'b011, 16'h8000, 16'h0001);
    chk("or_dout", dout, 16'h8001);
    chk("or_flags", {overflow, zero, negative, carry}, 4'b0010);
    do_op(3'b100, 16'haaaa, 16'haaaa);
    chk("xor_dout", dout, 16'h0000);
    chk("xor_flags", {overflow, zero, negative, carry}, 4'b0100);

    do_op(3'b000, 16'hffff, 16'h0001);
    chk("add_carry_dout", dout, 16'h0000);
    chk("add_carry_flags", {overflow, zero, negative, carry}, 4'b0101);

    do_op(3'b001, 16'h8000, 16'h0001);
    chk("sub_ovf_dout", dout, 16'h7fff);
    chk("sub_ovf_flags", {overflow, zero, negative, carry}, 4'b1001);

    // Back-to-back: start held high across two edges with new operands.
    do_op(3'b000, 16'h0001, 16'h0002);
    chk("b2b_first", {done, dout}, {1'b1, 16'h0003});
    start = 1'b1; op = 3'b001; a = 16'h000a; b = 16'h0003;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_second", {done, dout}, {1'b1, 16'h0007});

    mul_run(16'hfffd, 16'h0007, 0, lat, ndone, busy_ok);
    chk("mul_neg_lat", lat, 16);
    chk("mul_neg_ndone", ndone, 1);
    chk("mul_neg_busy", busy_ok, 1'b1);
    chk("mul_neg_dout", dout, 16'hffeb);
    chk("mul_neg_flags", {overflow, zero, negative, carry}, 4'b0010);

    mul_run(16'h0100, 16'h0100, 0, lat, ndone, busy_ok);
    chk("mul_ovf_lat", lat, 16);
    chk("mul_ovf_dout", dout, 16'h0000);
    chk("mul_ovf_flags", {overflow, zero, negative, carry}, 4'b1100);

    mul_run(16'h0005, 16'hfffe, 0, lat, ndone, busy_ok);
    chk("mul_negb_dout", dout, 16'hfff6);
    chk("mul_negb_flags", {overflow, zero, negative, carry}, 4'b0010);

    mul_run(16'h0003, 16'h0004, 5, lat, ndone, busy_ok);
    chk("mul_ign_lat", lat, 16);
    chk("mul_ign_ndone", ndone, 1);
    chk("mul_ign_busy", busy_ok, 1'b1);
    chk("mul_ign_dout", dout, 16'h000c);
    chk("mul_ign_flags", {overflow, zero, negative, carry}, 4'b0000);

    // Reset in the middle of a MUL.
    do_op(3'b111, 16'h0003, 16'h0005);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {busy, done, overflow, zero, negative, carry}, 6'b0);
    chk("rst_mid_dout", dout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_hold_dout", dout, 16'h0000);

    do_op(3'b000, 16'h0001, 16'h0001);
    chk("post_rst_add", {done, dout}, {1'b1, 16'h0002});
    chk("post_rst_flags", {overflow, zero, negative, carry}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
